uart_rx_deframer: RTL and testbench

- Receive-side frame decoder that consumes the falling-edge pulse on the synchronized RX line plus a 16x oversampling tick.
- Validates the start bit at mid-bit, then samples data bits LSB-first, optional parity and 1 or 2 stop bits.
- Presents the assembled character with error flags to the RX FIFO.
- Sits between the negative-edge detector on rx and the receive FIFO / status register.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_rx_deframer.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   rx_state_t     : receive deframer FSM encoding
//   DW_5 .. DW_8   : data_width_i encodings (character length 5..8 bits)
//   STOP_1, STOP_2 : stop_bits_i encodings
//   width_decode() : maps a data_width code to its bit count
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_IDLE = 3'd5
    } rx_state_t;

    localparam logic [1:0] DW_5 = 2'b00;
    localparam logic [1:0] DW_6 = 2'b01;
    localparam logic [1:0] DW_7 = 2'b10;
    localparam logic [1:0] DW_8 = 2'b11;

    localparam logic STOP_1 = 1'b0;
    localparam logic STOP_2 = 1'b1;

    // Character length in bits for a data_width code (5..8).
    function automatic logic [3:0] width_decode(input logic [1:0] code);
        return 4'd5 + {2'b00, code};
    endfunction

endpackage

// File: rtl/uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// uart_rx_deframer
// Receive-side UART frame decoder. Driven by a falling-edge pulse on the
// synchronized rx line and a 16x (OVERSAMPLE) tick, it validates the start
// bit at mid-bit, samples LSB-first data, optional parity and one or two stop
// bits, then presents the character plus error flags for one clock.
//
// Ports
//   clk_i          system clock
//   rst_n_i        asynchronous active-low reset
//   enable_i       receiver enable; low aborts any frame in progress
//   rx_i           synchronized serial line, idle high
//   start_edge_i   one-cycle pulse on rx_i falling edge
//   ov_tick_i      one-cycle pulse at OVERSAMPLE x baud
//   data_width_i   00=5, 01=6, 10=7, 11=8 data bits
//   parity_en_i    parity bit present
//   parity_odd_i   1=odd parity, 0=even parity
//   stop_bits_i    0=one stop bit, 1=two stop bits
//   data_o         received character, right-aligned, unused MSBs 0
//   data_valid_o   one-cycle pulse: data_o and error flags are valid
//   parity_err_o   parity mismatch (qualified by data_valid_o)
//   frame_err_o    a stop bit sampled 0 (qualified by data_valid_o)
//   break_o        all-zero frame incl. first stop bit (qualified by data_valid_o)
//   busy_o         FSM is not idle
// ---------------------------------------------------------------------------
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int MAX_WIDTH  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 enable_i,
    input  logic                 rx_i,
    input  logic                 start_edge_i,
    input  logic                 ov_tick_i,
    input  logic [1:0]           data_width_i,
    input  logic                 parity_en_i,
    input  logic                 parity_odd_i,
    input  logic                 stop_bits_i,
    output logic [MAX_WIDTH-1:0] data_o,
    output logic                 data_valid_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 break_o,
    output logic                 busy_o
);

    localparam int TICK_W    = $clog2(OVERSAMPLE);
    localparam int BIT_CNT_W = $clog2(MAX_WIDTH + 1);
    localparam int IDX_W     = $clog2(MAX_WIDTH);

    // Last tick count of the half bit (start validation) and of a full bit.
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);

    // FSM and counters
    rx_state_t              state_q, state_d;
    logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [MAX_WIDTH-1:0]   shift_q, shift_d;

    // Configuration captured on IDLE->START
    logic [BIT_CNT_W-1:0]   cfg_width_q, cfg_width_d;
    logic                   cfg_par_en_q, cfg_par_en_d;
    logic                   cfg_par_odd_q, cfg_par_odd_d;
    logic                   cfg_two_stop_q, cfg_two_stop_d;

    // In-flight frame status
    logic                   par_err_q, par_err_d;
    logic                   par_bit_q, par_bit_d;
    logic                   frame_err_q, frame_err_d;
    logic                   first_stop_q, first_stop_d;
    logic                   last_stop_q, last_stop_d;

    // Registered outputs
    logic [MAX_WIDTH-1:0]   data_q, data_d;
    logic                   data_valid_q, data_valid_d;
    logic                   parity_err_out_q, parity_err_out_d;
    logic                   frame_err_out_q, frame_err_out_d;
    logic                   break_q, break_d;

    logic                   tick_half;
    logic                   tick_full;
    logic [3:0]             width_req;
    logic [BIT_CNT_W-1:0]   stop_total;
    logic                   first_stop_val;

    assign tick_half = ov_tick_i && (tick_cnt_q == HALF_LAST);
    assign tick_full = ov_tick_i && (tick_cnt_q == FULL_LAST);

    // Requested character length, clamped to what data_o can hold.
    always_comb begin
        width_req = width_decode(data_width_i);
        if (width_req > 4'(MAX_WIDTH)) begin
            width_req = 4'(MAX_WIDTH);
        end
    end

    assign stop_total = (cfg_two_stop_q == STOP_2) ? BIT_CNT_W'(2) : BIT_CNT_W'(1);

    // The first stop bit is either being sampled right now or was stored.
    assign first_stop_val = (bit_cnt_q == '0) ? rx_i : first_stop_q;

    // NOTE: every *_d gets its hold value before the case statement, so no
    // path through this block leaves a variable unassigned (no latches).
    always_comb begin
        state_d          = state_q;
        tick_cnt_d       = tick_cnt_q;
        bit_cnt_d        = bit_cnt_q;
        shift_d          = shift_q;
        cfg_width_d      = cfg_width_q;
        cfg_par_en_d     = cfg_par_en_q;
        cfg_par_odd_d    = cfg_par_odd_q;
        cfg_two_stop_d   = cfg_two_stop_q;
        par_err_d        = par_err_q;
        par_bit_d        = par_bit_q;
        frame_err_d      = frame_err_q;
        first_stop_d     = first_stop_q;
        last_stop_d      = last_stop_q;
        data_d           = data_q;
        data_valid_d     = 1'b0;
        parity_err_out_d = parity_err_out_q;
        frame_err_out_d  = frame_err_out_q;
        break_d          = break_q;

        if (state_q != RX_IDLE && !enable_i) begin
            // Abort: drop the frame without touching the output registers.
            state_d    = RX_IDLE;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
        end else begin
            case (state_q)
                RX_IDLE: begin
                    // A tick coinciding with the edge is deliberately not counted.
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    if (start_edge_i && enable_i) begin
                        state_d        = RX_START;
                        cfg_width_d    = BIT_CNT_W'(width_req);
                        cfg_par_en_d   = parity_en_i;
                        cfg_par_odd_d  = parity_odd_i;
                        cfg_two_stop_d = stop_bits_i;
                        shift_d        = '0;
                        par_err_d      = 1'b0;
                        par_bit_d      = 1'b0;
                        frame_err_d    = 1'b0;
                        first_stop_d   = 1'b0;
                        last_stop_d    = 1'b0;
                    end
                end

                RX_START: begin
                    if (tick_half) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        // A line already back high at mid-bit was a glitch.
                        state_d    = rx_i ? RX_IDLE : RX_DATA;
                    end else if (ov_tick_i) begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end

                RX_DATA: begin
                    if (tick_full) begin
                        tick_cnt_d                      = '0;
                        shift_d[bit_cnt_q[IDX_W-1:0]]   = rx_i;
                        if (bit_cnt_q == cfg_width_q - BIT_CNT_W'(1)) begin
                            bit_cnt_d = '0;
                            state_d   = cfg_par_en_q ? RX_PARITY : RX_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        end
                    end else if (ov_tick_i) begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end

                RX_PARITY: begin
                    if (tick_full) begin
                        tick_cnt_d = '0;
                        par_bit_d  = rx_i;
                        // Unused MSBs of shift_q are zero, so a full-width XOR is safe.
                        par_err_d  = ((^shift_q) ^ rx_i) != cfg_par_odd_q;
                        state_d    = RX_STOP;
                    end else if (ov_tick_i) begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end

                RX_STOP: begin
                    if (bit_cnt_q == stop_total) begin
                        // Cycle in which data_valid_o is high; leave afterwards so
                        // busy_o drops one cycle after the valid pulse.
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = last_stop_q ? RX_IDLE : RX_WAIT_IDLE;
                    end else if (tick_full) begin
                        tick_cnt_d  = '0;
                        bit_cnt_d   = bit_cnt_q + BIT_CNT_W'(1);
                        last_stop_d = rx_i;
                        frame_err_d = frame_err_q | ~rx_i;
                        if (bit_cnt_q == '0) begin
                            first_stop_d = rx_i;
                        end
                        if (bit_cnt_q + BIT_CNT_W'(1) == stop_total) begin
                            data_valid_d     = 1'b1;
                            data_d           = shift_q;
                            parity_err_out_d = cfg_par_en_q & par_err_q;
                            frame_err_out_d  = frame_err_q | ~rx_i;
                            break_d          = (shift_q == '0)
                                             && !(cfg_par_en_q && par_bit_q)
                                             && !first_stop_val;
                        end
                    end else if (ov_tick_i) begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end

                RX_WAIT_IDLE: begin
                    // Line held low after the frame: wait for it to release
                    // before another start edge can be accepted.
                    if (rx_i) begin
                        state_d = RX_IDLE;
                    end
                end

                default: begin
                    state_d    = RX_IDLE;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q          <= RX_IDLE;
            tick_cnt_q       <= '0;
            bit_cnt_q        <= '0;
            shift_q          <= '0;
            cfg_width_q      <= '0;
            cfg_par_en_q     <= 1'b0;
            cfg_par_odd_q    <= 1'b0;
            cfg_two_stop_q   <= 1'b0;
            par_err_q        <= 1'b0;
            par_bit_q        <= 1'b0;
            frame_err_q      <= 1'b0;
            first_stop_q     <= 1'b0;
            last_stop_q      <= 1'b0;
            data_q           <= '0;
            data_valid_q     <= 1'b0;
            parity_err_out_q <= 1'b0;
            frame_err_out_q  <= 1'b0;
            break_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            tick_cnt_q       <= tick_cnt_d;
            bit_cnt_q        <= bit_cnt_d;
            shift_q          <= shift_d;
            cfg_width_q      <= cfg_width_d;
            cfg_par_en_q     <= cfg_par_en_d;
            cfg_par_odd_q    <= cfg_par_odd_d;
            cfg_two_stop_q   <= cfg_two_stop_d;
            par_err_q        <= par_err_d;
            par_bit_q        <= par_bit_d;
            frame_err_q      <= frame_err_d;
            first_stop_q     <= first_stop_d;
            last_stop_q      <= last_stop_d;
            data_q           <= data_d;
            data_valid_q     <= data_valid_d;
            parity_err_out_q <= parity_err_out_d;
            frame_err_out_q  <= frame_err_out_d;
            break_q          <= break_d;
        end
    end

    assign data_o       = data_q;
    assign data_valid_o = data_valid_q;
    assign parity_err_o = parity_err_out_q;
    assign frame_err_o  = frame_err_out_q;
    assign break_o      = break_q;
    assign busy_o       = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_deframer
// Directed bench for uart_rx_deframer (OVERSAMPLE=16, MAX_WIDTH=8). One
// oversample tick every 4 clocks; the line is driven one bit per 16 ticks.
// ---------------------------------------------------------------------------
module tb_uart_rx_deframer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b1;
    logic       rx = 1'b1;
    logic       start_edge = 1'b0;
    logic       ov_tick = 1'b0;
    logic [1:0] data_width = 2'b11;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       stop_bits = 1'b0;

    logic [7:0] data_o;
    logic       data_valid_o;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       break_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;

    // Observation of the valid pulse relative to the tick stream.
    int   valid_cnt = 0;
    int   valid_ticks = 0;
    int   tick_count = 0;
    logic tick_prev = 1'b0;
    logic valid_after_tick = 1'b0;
    logic valid_busy = 1'b0;
    logic busy_after = 1'b0;
    logic valid_d1 = 1'b0;

    always #5 clk = ~clk;

    uart_rx_deframer #(
        .OVERSAMPLE (16),
        .MAX_WIDTH  (8)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .enable_i     (enable),
        .rx_i         (rx),
        .start_edge_i (start_edge),
        .ov_tick_i    (ov_tick),
        .data_width_i (data_width),
        .parity_en_i  (parity_en),
        .parity_odd_i (parity_odd),
        .stop_bits_i  (stop_bits),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .parity_err_o (parity_err_o),
        .frame_err_o  (frame_err_o),
        .break_o      (break_o),
        .busy_o       (busy_o)
    );

    always @(posedge clk) begin
        if (valid_d1) busy_after <= busy_o;
        if (data_valid_o) begin
            valid_cnt        <= valid_cnt + 1;
            valid_ticks      <= tick_count;
            valid_after_tick <= tick_prev;
            valid_busy       <= busy_o;
        end
        valid_d1  <= data_valid_o;
        tick_prev <= ov_tick;
        if (start_edge) tick_count <= 0;
        else if (ov_tick) tick_count <= tick_count + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); ov_tick = 1'b1;
            @(negedge clk); ov_tick = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    // Start bit plus nbits of seq (LSB first), 16 ticks each; then end_level.
    task automatic send_frame(input logic [15:0] seq, input int nbits, input logic end_level);
        @(negedge clk); rx = 1'b0; start_edge = 1'b1;
        @(negedge clk); start_edge = 1'b0;
        tick_n(16);
        for (int i = 0; i < nbits; i++) begin
            rx = seq[i];
            tick_n(16);
        end
        rx = end_level;
        tick_n(4);
    endtask

    task automatic set_cfg(input logic [1:0] w, input logic pe, input logic po, input logic sb);
        data_width = w; parity_en = pe; parity_odd = po; stop_bits = sb;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({data_o, data_valid_o, parity_err_o, frame_err_o, break_o, busy_o} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h v=%b pe=%b fe=%b brk=%b busy=%b expected all 0",
                     data_o, data_valid_o, parity_err_o, frame_err_o, break_o, busy_o);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL reset_idle: busy=%b expected 0", busy_o);
        end
    endtask

    task automatic test_8n1;
        int v0;
        v0 = valid_cnt;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        send_frame({7'h7F, 1'b1, 8'hA5}, 9, 1'b1);
        checks++;
        if (valid_cnt !== v0 + 1) begin
            errors++; $display("FAIL a5_valid_count: got %0d expected %0d", valid_cnt - v0, 1);
        end
        checks++;
        if (valid_ticks !== 152 || valid_after_tick !== 1'b1) begin
            errors++; $display("FAIL a5_latency: got tick %0d prev_tick=%b expected 152 and 1",
                               valid_ticks, valid_after_tick);
        end
        checks++;
        if (data_o !== 8'hA5) begin
            errors++; $display("FAIL a5_data: got %h expected a5", data_o);
        end
        checks++;
        if ({parity_err_o, frame_err_o, break_o} !== 3'b000) begin
            errors++; $display("FAIL a5_flags: got pe/fe/brk=%b expected 000",
                               {parity_err_o, frame_err_o, break_o});
        end
        checks++;
        if (valid_busy !== 1'b1 || busy_after !== 1'b0) begin
            errors++; $display("FAIL a5_busy_fall: got busy during valid=%b after=%b expected 1 and 0",
                               valid_busy, busy_after);
        end
    endtask

    task automatic test_7e1_parity;
        int v0;
        v0 = valid_cnt;
        set_cfg(2'b10, 1'b1, 1'b0, 1'b0);
        // 0x41 has two ones: even parity bit would be 0, drive 1 instead.
        send_frame({7'h7F, 1'b1, 1'b1, 7'h41}, 9, 1'b1);
        checks++;
        if (valid_cnt !== v0 + 1 || valid_ticks !== 152) begin
            errors++; $display("FAIL 7e1_valid: got count %0d tick %0d expected 1 and 152",
                               valid_cnt - v0, valid_ticks);
        end
        checks++;
        if (data_o !== 8'h41) begin
            errors++; $display("FAIL 7e1_data: got %h expected 41", data_o);
        end
        checks++;
        if ({parity_err_o, frame_err_o, break_o} !== 3'b100) begin
            errors++; $display("FAIL 7e1_flags: got pe/fe/brk=%b expected 100",
                               {parity_err_o, frame_err_o, break_o});
        end
    endtask

    task automatic test_5o2_frame;
        int v0;
        v0 = valid_cnt;
        set_cfg(2'b00, 1'b1, 1'b1, 1'b1);
        // 0x13 has three ones: odd parity bit 0; stop1=1, stop2=0.
        send_frame({8'h00, 1'b0, 1'b1, 1'b0, 5'h13}, 8, 1'b0);
        checks++;
        if (valid_cnt !== v0 + 1 || valid_ticks !== 136) begin
            errors++; $display("FAIL 5o2_valid: got count %0d tick %0d expected 1 and 136",
                               valid_cnt - v0, valid_ticks);
        end
        checks++;
        if (data_o !== 8'h13) begin
            errors++; $display("FAIL 5o2_data: got %h expected 13", data_o);
        end
        checks++;
        if ({parity_err_o, frame_err_o, break_o} !== 3'b010) begin
            errors++; $display("FAIL 5o2_flags: got pe/fe/brk=%b expected 010",
                               {parity_err_o, frame_err_o, break_o});
        end
        @(negedge clk); start_edge = 1'b1;
        @(negedge clk); start_edge = 1'b0;
        tick_n(2);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++; $display("FAIL 5o2_wait_idle: busy=%b expected 1", busy_o);
        end
        rx = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL 5o2_release: busy=%b expected 0", busy_o);
        end
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        tick_n(20);
        checks++;
        if (busy_o !== 1'b0 || valid_cnt !== v0 + 1) begin
            errors++; $display("FAIL 5o2_edge_ignored: busy=%b count %0d expected 0 and 1",
                               busy_o, valid_cnt - v0);
        end
    endtask

    task automatic test_glitch;
        int v0;
        v0 = valid_cnt;
        @(negedge clk); rx = 1'b0; start_edge = 1'b1;
        @(negedge clk); start_edge = 1'b0;
        tick_n(4);
        rx = 1'b1;
        tick_n(3);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++; $display("FAIL glitch_tick7_busy: busy=%b expected 1", busy_o);
        end
        tick_n(1);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL glitch_tick8_idle: busy=%b expected 0", busy_o);
        end
        tick_n(8);
        checks++;
        if (valid_cnt !== v0 || data_o !== 8'h13) begin
            errors++; $display("FAIL glitch_no_output: count %0d data %h expected 0 and 13",
                               valid_cnt - v0, data_o);
        end
    endtask

    task automatic test_enable_abort;
        int v0;
        v0 = valid_cnt;
        @(negedge clk); rx = 1'b0; start_edge = 1'b1;
        @(negedge clk); start_edge = 1'b0;
        tick_n(16);
        rx = 1'b1;
        tick_n(16 * 3 + 4);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++; $display("FAIL abort_busy_before: busy=%b expected 1", busy_o);
        end
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL abort_idle: busy=%b expected 0", busy_o);
        end
        enable = 1'b1;
        tick_n(100);
        checks++;
        if (valid_cnt !== v0 || data_o !== 8'h13 || busy_o !== 1'b0) begin
            errors++; $display("FAIL abort_no_output: count %0d data %h busy %b expected 0, 13, 0",
                               valid_cnt - v0, data_o, busy_o);
        end
    endtask

    task automatic test_reset_midframe;
        int v0;
        @(negedge clk); rx = 1'b0; start_edge = 1'b1;
        @(negedge clk); start_edge = 1'b0;
        tick_n(30);
        v0 = valid_cnt;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({data_o, data_valid_o, parity_err_o, frame_err_o, break_o, busy_o} !== 13'd0) begin
            errors++;
            $display("FAIL midreset_async: got data=%h v=%b pe=%b fe=%b brk=%b busy=%b expected all 0",
                     data_o, data_valid_o, parity_err_o, frame_err_o, break_o, busy_o);
        end
        @(negedge clk); rx = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick_n(20);
        checks++;
        if (valid_cnt !== v0) begin
            errors++; $display("FAIL midreset_no_valid: count %0d expected 0", valid_cnt - v0);
        end
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        send_frame({7'h7F, 1'b1, 8'h3C}, 9, 1'b1);
        checks++;
        if (valid_cnt !== v0 + 1 || valid_ticks !== 152) begin
            errors++; $display("FAIL 3c_valid: got count %0d tick %0d expected 1 and 152",
                               valid_cnt - v0, valid_ticks);
        end
        checks++;
        if (data_o !== 8'h3C || {parity_err_o, frame_err_o, break_o} !== 3'b000) begin
            errors++; $display("FAIL 3c_data: got %h flags %b expected 3c and 000",
                               data_o, {parity_err_o, frame_err_o, break_o});
        end
    endtask

    task automatic test_break;
        int v0;
        v0 = valid_cnt;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        send_frame(16'h0000, 9, 1'b0);
        tick_n(16 * 10);
        checks++;
        if (valid_cnt !== v0 + 1 || valid_ticks !== 152) begin
            errors++; $display("FAIL break_valid: got count %0d tick %0d expected 1 and 152",
                               valid_cnt - v0, valid_ticks);
        end
        checks++;
        if (data_o !== 8'h00 || {parity_err_o, frame_err_o, break_o} !== 3'b011) begin
            errors++; $display("FAIL break_flags: got data %h pe/fe/brk=%b expected 00 and 011",
                               data_o, {parity_err_o, frame_err_o, break_o});
        end
        checks++;
        if (busy_o !== 1'b1) begin
            errors++; $display("FAIL break_wait_idle: busy=%b expected 1", busy_o);
        end
        rx = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL break_release: busy=%b expected 0", busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_7e1_parity();
        test_5o2_frame();
        test_glitch();
        test_enable_abort();
        test_reset_midframe();
        test_break();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
